mtl_slide_ctrl: RTL and testbench

Avalon-MM slave that owns the slide index for the MTL display path. It accepts next/prev/goto commands from the CPU and optionally advances slides on a programmable timer. It enforces a hold-off window between accepted changes, which debounces touch-driven command bursts. It drives the current slide index and a one-cycle change pulse to the display pipeline, and exposes index, target, status and auto-period registers for readback.

---
 rtl/mtl_slide_ctrl.sv | 91 +++++++++
 tb/tb_mtl_slide_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mtl_slide_ctrl.sv
// mtl_slide_ctrl: Avalon-MM slide index controller with hold-off and timed auto-advance
module mtl_slide_ctrl #(
  parameter int NUM_SLIDES     = 16,
  parameter int HOLDOFF_CYCLES = 1024,
  parameter int TICK_DIV       = 50000,
  parameter int IDX_W          = $clog2(NUM_SLIDES)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       avs_s0_address,
  input  logic             avs_s0_write,
  input  logic [7:0]       avs_s0_writedata,
  input  logic             avs_s0_read,
  output logic [7:0]       avs_s0_readdata,
  output logic [IDX_W-1:0] slide_idx,
  output logic             slide_change_pulse
);
  localparam int HW = HOLDOFF_CYCLES > 0 ? $clog2(HOLDOFF_CYCLES + 1) : 1;
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_SLIDES - 1);
  localparam logic [HW-1:0] HOLD_LD = HW'(HOLDOFF_CYCLES);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [IDX_W-1:0] idx_q, idx_d, idx_next, idx_prev, cmd_idx;
  logic             pulse_q, pulse_d, err_q, err_d;
  logic [7:0]       rdata_q, rdata_d, target_q, target_d, auto_q, auto_d, tick_q, tick_d, status;
  logic [HW-1:0]    hold_q, hold_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             wr_cmd, wr_target, wr_auto, rd_status, busy, auto_on, tick, auto_hit;
  logic             goto_ok, cmd_bad, accept;

  always_comb begin
    wr_cmd    = avs_s0_write && avs_s0_address == 2'd0 && |avs_s0_writedata[2:0];
    wr_target = avs_s0_write && avs_s0_address == 2'd1;
    wr_auto   = avs_s0_write && avs_s0_address == 2'd3;
    rd_status = avs_s0_read && avs_s0_address == 2'd2;
    busy      = hold_q != '0;
    auto_on   = auto_q != 8'd0;
    tick      = auto_on && pre_q == PRE_LAST;
    auto_hit  = auto_on && tick_q == auto_q;
    goto_ok   = {1'b0, target_q} < 9'(NUM_SLIDES);
    idx_next  = idx_q == LAST ? '0 : idx_q + 1'b1;
    idx_prev  = idx_q == '0 ? LAST : idx_q - 1'b1;
    // GOTO > PREV > NEXT when several command bits are set
    cmd_idx   = avs_s0_writedata[2] ? target_q[IDX_W-1:0] : avs_s0_writedata[1] ? idx_prev : idx_next;
    cmd_bad   = avs_s0_writedata[2] && !goto_ok;
    // a command write suppresses a coincident auto event even if the command is dropped
    accept    = !busy && (wr_cmd ? !cmd_bad : auto_hit);
    idx_d     = accept ? (wr_cmd ? cmd_idx : idx_next) : idx_q;
    pulse_d   = accept;
    hold_d    = accept ? HOLD_LD : busy ? hold_q - 1'b1 : hold_q;
    err_d     = (wr_cmd && cmd_bad && !busy) || (err_q && !rd_status);
    target_d  = wr_target ? avs_s0_writedata : target_q;
    auto_d    = wr_auto ? avs_s0_writedata : auto_q;
    pre_d     = (wr_auto || !auto_on || tick) ? '0 : pre_q + 1'b1;
    tick_d    = (accept || wr_auto || auto_hit) ? 8'd0 : tick ? tick_q + 1'b1 : tick_q;
    status    = {err_q, busy, 6'd0} | 8'(idx_q);
    rdata_d   = !avs_s0_read ? rdata_q :
                avs_s0_address == 2'd0 ? 8'd0 :
                avs_s0_address == 2'd1 ? target_q :
                avs_s0_address == 2'd2 ? status : auto_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q    <= '0;
      pulse_q  <= 1'b0;
      rdata_q  <= 8'd0;
      target_q <= 8'd0;
      auto_q   <= 8'd0;
      err_q    <= 1'b0;
      hold_q   <= '0;
      pre_q    <= '0;
      tick_q   <= 8'd0;
    end else begin
      idx_q    <= idx_d;
      pulse_q  <= pulse_d;
      rdata_q  <= rdata_d;
      target_q <= target_d;
      auto_q   <= auto_d;
      err_q    <= err_d;
      hold_q   <= hold_d;
      pre_q    <= pre_d;
      tick_q   <= tick_d;
    end
  end

  assign avs_s0_readdata    = rdata_q;
  assign slide_idx          = idx_q;
  assign slide_change_pulse = pulse_q;
endmodule

// File: tb/tb_mtl_slide_ctrl.sv
// tb_mtl_slide_ctrl: directed vectors with hand-computed expectations for mtl_slide_ctrl
module tb_mtl_slide_ctrl;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] avs_s0_address = 2'd0;
  logic       avs_s0_write = 1'b0;
  logic [7:0] avs_s0_writedata = 8'd0;
  logic       avs_s0_read = 1'b0;
  logic [7:0] avs_s0_readdata;
  logic [3:0] slide_idx;
  logic       slide_change_pulse;
  int         n_vec = 0;
  int         n_bad = 0;
  int         n;
  logic [7:0] rd_val;

  mtl_slide_ctrl #(.NUM_SLIDES(16), .HOLDOFF_CYCLES(4), .TICK_DIV(10)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .avs_s0_address(avs_s0_address),
    .avs_s0_write(avs_s0_write),
    .avs_s0_writedata(avs_s0_writedata),
    .avs_s0_read(avs_s0_read),
    .avs_s0_readdata(avs_s0_readdata),
    .slide_idx(slide_idx),
    .slide_change_pulse(slide_change_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    avs_s0_address = a;
    avs_s0_writedata = d;
    avs_s0_write = 1'b1;
    step(1);
    avs_s0_write = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    avs_s0_address = a;
    avs_s0_read = 1'b1;
    step(1);
    avs_s0_read = 1'b0;
    d = avs_s0_readdata;
  endtask

  // edges until a pulse is seen (1-based), 0 if none within max
  task automatic wait_pulse(input int max, output int cnt);
    int i;
    cnt = 0;
    i = 0;
    while (cnt == 0 && i < max) begin
      step(1);
      i++;
      if (slide_change_pulse) cnt = i;
    end
  endtask

  initial begin
    #12;
    chk("rst_idx", slide_idx, 0);
    chk("rst_pulse", slide_change_pulse, 0);
    chk("rst_rdata", avs_s0_readdata, 0);
    reset_n = 1'b1;
    step(1);

    for (int s = 1; s <= 3; s++) begin
      wr(2'd0, 8'h01);
      chk("next_idx", slide_idx, s);
      chk("next_pulse", slide_change_pulse, 1);
      step(1);
      chk("next_pulse_drop", slide_change_pulse, 0);
      step(8);
    end
    rd(2'd2, rd_val);
    chk("status_3", rd_val, 8'h03);

    wr(2'd1, 8'd0);
    wr(2'd0, 8'h04);
    chk("goto_0", slide_idx, 0);
    step(5);
    wr(2'd0, 8'h02);
    chk("prev_wrap", slide_idx, 15);
    step(5);
    wr(2'd0, 8'h01);
    chk("next_wrap", slide_idx, 0);
    step(5);

    wr(2'd0, 8'h01);
    chk("ho_c0", slide_idx, 1);
    rd(2'd2, rd_val);
    chk("ho_busy_c1", rd_val, 8'h41);
    wr(2'd0, 8'h01);
    chk("ho_drop_idx", slide_idx, 1);
    chk("ho_drop_pulse", slide_change_pulse, 0);
    rd(2'd2, rd_val);
    chk("ho_busy_c3", rd_val, 8'h41);
    rd(2'd2, rd_val);
    chk("ho_busy_c4", rd_val, 8'h41);
    wr(2'd0, 8'h01);
    chk("ho_c5_idx", slide_idx, 2);
    chk("ho_c5_pulse", slide_change_pulse, 1);
    step(5);

    wr(2'd1, 8'd7);
    wr(2'd0, 8'h07);
    chk("goto_prio", slide_idx, 7);
    chk("goto_pulse", slide_change_pulse, 1);
    step(5);
    wr(2'd1, 8'd20);
    wr(2'd0, 8'h04);
    chk("goto_bad_idx", slide_idx, 7);
    chk("goto_bad_pulse", slide_change_pulse, 0);
    rd(2'd2, rd_val);
    chk("err_set", rd_val, 8'h87);
    rd(2'd2, rd_val);
    chk("err_clr", rd_val, 8'h07);
    rd(2'd1, rd_val);
    chk("target_rb", rd_val, 8'd20);
    wr(2'd1, 8'd7);
    wr(2'd0, 8'h04);
    chk("goto_same_pulse", slide_change_pulse, 1);
    rd(2'd2, rd_val);
    chk("goto_same_busy", rd_val, 8'h47);
    step(5);

    wr(2'd3, 8'd3);
    wait_pulse(60, n);
    chk("auto_first", n, 31);
    chk("auto_idx1", slide_idx, 8);
    wait_pulse(60, n);
    chk("auto_period", n, 30);
    chk("auto_idx2", slide_idx, 9);
    step(10);
    wr(2'd0, 8'h01);
    chk("auto_next_idx", slide_idx, 10);
    wait_pulse(60, n);
    chk("auto_restart", n, 29);
    chk("auto_idx3", slide_idx, 11);
    wr(2'd3, 8'd0);
    wait_pulse(70, n);
    chk("auto_off", n, 0);

    wr(2'd3, 8'd2);
    rd(2'd1, rd_val);
    chk("pre_rst_rdata", rd_val, 8'd7);
    wr(2'd0, 8'h01);
    chk("pre_rst_pulse", slide_change_pulse, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_idx", slide_idx, 0);
    chk("arst_pulse", slide_change_pulse, 0);
    chk("arst_rdata", avs_s0_readdata, 0);
    step(2);
    reset_n = 1'b1;
    wait_pulse(60, n);
    chk("post_rst_quiet", n, 0);
    rd(2'd3, rd_val);
    chk("post_rst_auto", rd_val, 0);
    wr(2'd0, 8'h01);
    chk("post_rst_next", slide_idx, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
